multi_debounce_counter: RTL and testbench

- Parametrised successor to the single-button debounced decade counter used for VGA board inputs.
- CHANNELS independent pushbutton channels, each with its own synchroniser, debounce filter, edge detector, optional hold auto-repeat and up/down modulo counter.
- Sits between the raw board buttons and the display/control logic; counts are packed into one bus for the VGA overlay.

---
 rtl/multi_debounce_counter.sv | 143 ++++++++++++++
 tb/tb_multi_debounce_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce_counter.sv
// rtl/multi_debounce_counter.sv - per-channel debounced pushbutton up/down modulo counters with optional hold auto-repeat
module multi_debounce_counter #(
    parameter int CHANNELS    = 2,
    parameter int DB_BITS     = 11,
    parameter int CNT_W       = 4,
    parameter int MODULO      = 10,
    parameter int EDGE        = 0,
    parameter int REPEAT_EN   = 0,
    parameter int HOLD_CYCLES = 1024,
    parameter int RATE_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       button_in,
    input  logic [CHANNELS-1:0]       dir_up,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       db_level,
    output logic [CHANNELS-1:0]       step,
    output logic [CHANNELS-1:0]       wrap
);
    // One counter serves both the initial hold delay and the repeat period.
    localparam int HR_MAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
    localparam int HR_W   = $clog2(HR_MAX);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(MODULO - 1);

    logic [CHANNELS-1:0] s1_q, s2_q, db_q, db_dly_q;
    logic [DB_BITS-1:0]  db_cnt_q [CHANNELS];
    logic [HR_W-1:0]     hr_cnt_q [CHANNELS];
    logic [CHANNELS-1:0] fired_q;
    logic [CNT_W-1:0]    count_q  [CHANNELS];
    logic [CNT_W-1:0]    count_d  [CHANNELS];
    logic [CHANNELS-1:0] step_q, step_d, wrap_q, wrap_d;
    logic [CHANNELS-1:0] press, rel_ev, rep_fire, step_ev;

    // Synchronise raw buttons, run the stability counters and update the debounced level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < CHANNELS; i++) db_cnt_q[i] <= '0;
        end else begin
            s1_q     <= button_in;
            s2_q     <= s1_q;
            db_dly_q <= db_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s1_q[i] != s2_q[i])
                    db_cnt_q[i] <= '0;
                else if (!db_cnt_q[i][DB_BITS-1])
                    db_cnt_q[i] <= db_cnt_q[i] + DB_BITS'(1);
                if (db_cnt_q[i][DB_BITS-1])
                    db_q[i] <= s2_q[i];
            end
        end
    end

    // Repeat fires after the hold delay, then once per rate period while still pressed.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rep_fire[i] = (REPEAT_EN != 0) && db_q[i] &&
                          (fired_q[i] ? (hr_cnt_q[i] == HR_W'(RATE_CYCLES - 1))
                                      : (hr_cnt_q[i] == HR_W'(HOLD_CYCLES - 1)));
        end
    end

    // Hold/rate counter and repeat-fired flag; both idle at zero while released or when repeat is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fired_q <= '0;
            for (int i = 0; i < CHANNELS; i++) hr_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((REPEAT_EN == 0) || !db_q[i]) begin
                    hr_cnt_q[i] <= '0;
                    fired_q[i]  <= 1'b0;
                end else if (rep_fire[i]) begin
                    hr_cnt_q[i] <= '0;
                    fired_q[i]  <= 1'b1;
                end else begin
                    hr_cnt_q[i] <= hr_cnt_q[i] + HR_W'(1);
                end
            end
        end
    end

    // A release that ends an auto-repeating press must not add one more step.
    assign press   = db_q & ~db_dly_q;
    assign rel_ev  = ~db_q & db_dly_q;
    assign step_ev = ((EDGE != 0) ? press : (rel_ev & ~fired_q)) | rep_fire;

    // Next count per channel: clear wins over a step, steps wrap at both ends of the range.
    always_comb begin
        count_d = count_q;
        step_d  = '0;
        wrap_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
                count_d[i] = '0;
            end else if (step_ev[i]) begin
                step_d[i] = 1'b1;
                if (dir_up[i]) begin
                    if (count_q[i] == TOP) begin
                        count_d[i] = '0;
                        wrap_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + CNT_W'(1);
                    end
                end else begin
                    if (count_q[i] == '0) begin
                        count_d[i] = TOP;
                        wrap_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Register counts together with their step and wrap pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= '0;
            wrap_q <= '0;
            for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
        end else begin
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign count[g*CNT_W +: CNT_W] = count_q[g];
    end

    assign db_level = db_q;
    assign step     = step_q;
    assign wrap     = wrap_q;
endmodule

// File: tb/tb_multi_debounce_counter.sv
// tb/tb_multi_debounce_counter.sv - randomized scoreboard bench for multi_debounce_counter
module tb_multi_debounce_counter;
    localparam int CH   = 2;
    localparam int DBB  = 4;
    localparam int CW   = 4;
    localparam int MOD  = 10;
    localparam int HOLD = 32;
    localparam int RATE = 8;
    localparam int W    = 1 << (DBB - 1);
    localparam int HL   = W + 3;
    localparam int NI   = 3;
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CH-1:0] button_in = '0;
    logic [CH-1:0] dir_up = '0;
    logic [CH-1:0] clear = '0;
    logic [CH*CW-1:0] count_o [NI];
    logic [CH-1:0] db_o [NI];
    logic [CH-1:0] step_o [NI];
    logic [CH-1:0] wrap_o [NI];

    always #5 clk = ~clk;

    multi_debounce_counter #(.CHANNELS(CH), .DB_BITS(DBB), .CNT_W(CW), .MODULO(MOD), .EDGE(0),
        .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE)) dut_a (
        .clk(clk), .reset(reset), .button_in(button_in), .dir_up(dir_up), .clear(clear),
        .count(count_o[0]), .db_level(db_o[0]), .step(step_o[0]), .wrap(wrap_o[0]));

    multi_debounce_counter #(.CHANNELS(CH), .DB_BITS(DBB), .CNT_W(CW), .MODULO(MOD), .EDGE(1),
        .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE)) dut_b (
        .clk(clk), .reset(reset), .button_in(button_in), .dir_up(dir_up), .clear(clear),
        .count(count_o[1]), .db_level(db_o[1]), .step(step_o[1]), .wrap(wrap_o[1]));

    multi_debounce_counter #(.CHANNELS(CH), .DB_BITS(DBB), .CNT_W(CW), .MODULO(MOD), .EDGE(0),
        .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE)) dut_c (
        .clk(clk), .reset(reset), .button_in(button_in), .dir_up(dir_up), .clear(clear),
        .count(count_o[2]), .db_level(db_o[2]), .step(step_o[2]), .wrap(wrap_o[2]));

    int m_edge [NI] = '{0, 1, 0};
    int m_rep  [NI] = '{0, 1, 1};

    typedef struct {
        int edge_n;
        int cnt;
        bit wr;
    } step_t;

    int    hist [CH][$];
    bit    db_now [CH];
    bit    db_prev [CH];
    int    rise [CH];
    int    mcnt [NI][CH];
    step_t sb [NI*CH][$];
    int    ecount = 0;
    int    total = 0;
    int    bad = 0;
    bit    done = 0;

    task automatic chk(input string name, input int k, input int c, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d ch=%0d edge=%0d got=%0d want=%0d", name, k, c, ecount, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            for (int j = 0; j < HL; j++) hist[c].push_back(0);
            db_now[c]  = 1'b0;
            db_prev[c] = 1'b0;
            rise[c]    = 0;
            for (int k = 0; k < NI; k++) mcnt[k][c] = 0;
        end
    endtask

    // Reference: the debounced level follows the button once its last W+1 synchronised samples agree;
    // steps come from level edges and from hold time measured since the rising edge.
    task automatic model_step();
        ecount++;
        for (int c = 0; c < CH; c++) begin
            bit press;
            bit rel;
            bit same;
            press = db_now[c] && !db_prev[c];
            rel   = !db_now[c] && db_prev[c];
            for (int k = 0; k < NI; k++) begin
                bit    ev;
                int    h;
                step_t s;
                ev = (m_edge[k] != 0) ? press : rel;
                if (m_rep[k] != 0) begin
                    if (db_now[c]) begin
                        h = ecount - 1 - rise[c];
                        if (h == HOLD - 1 || (h > HOLD - 1 && (h - (HOLD - 1)) % RATE == 0)) ev = 1'b1;
                    end
                    if (m_edge[k] == 0 && rel && (ecount - 2 - rise[c]) >= HOLD - 1) ev = 1'b0;
                end
                if (clear[c]) begin
                    mcnt[k][c] = 0;
                end else if (ev) begin
                    s.wr = 1'b0;
                    if (dir_up[c]) begin
                        if (mcnt[k][c] == MOD - 1) begin mcnt[k][c] = 0; s.wr = 1'b1; end
                        else mcnt[k][c] = mcnt[k][c] + 1;
                    end else begin
                        if (mcnt[k][c] == 0) begin mcnt[k][c] = MOD - 1; s.wr = 1'b1; end
                        else mcnt[k][c] = mcnt[k][c] - 1;
                    end
                    s.edge_n = ecount;
                    s.cnt    = mcnt[k][c];
                    sb[k*CH + c].push_back(s);
                end
            end
            hist[c].push_back(int'(button_in[c]));
            void'(hist[c].pop_front());
            same = 1'b1;
            for (int j = 1; j <= W; j++) if (hist[c][j] != hist[c][0]) same = 1'b0;
            db_prev[c] = db_now[c];
            if (same) begin
                if (hist[c][W] == 1 && !db_now[c]) rise[c] = ecount;
                db_now[c] = (hist[c][W] == 1);
            end
        end
    endtask

    // Monitor: compare levels and counts every cycle; match each step pulse against the scoreboard.
    initial begin
        step_t s;
        bit    due;
        int    id;
        forever begin
            @(negedge clk);
            if (done) break;
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < CH; c++) begin
                    id = k*CH + c;
                    chk("db_level", k, c, int'(db_o[k][c]), int'(db_now[c]));
                    chk("count", k, c, int'(count_o[k][c*CW +: CW]), mcnt[k][c]);
                    due = (sb[id].size() > 0) && (sb[id][0].edge_n <= ecount);
                    chk("step", k, c, int'(step_o[k][c]), int'(due));
                    if (due) begin
                        s = sb[id].pop_front();
                        chk("step_count", k, c, int'(count_o[k][c*CW +: CW]), s.cnt);
                        chk("wrap", k, c, int'(wrap_o[k][c]), int'(s.wr));
                    end else begin
                        chk("wrap_idle", k, c, int'(wrap_o[k][c]), 0);
                    end
                end
            end
        end
    end

    // Driver: random bouncing/held button segments, random direction, clears aimed at step cycles, two resets mid-hold.
    initial begin
        int seg_left [CH];
        bit lvl [CH];
        model_reset();
        for (int c = 0; c < CH; c++) begin
            seg_left[c] = 0;
            lvl[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            if (!reset) model_step();
            reset = ((n >= 1500 && n < 1503) || (n >= 3200 && n < 3204));
            if (reset) model_reset();
            if (n == 1460 || n == 3160) begin
                lvl[0] = 1'b1;
                seg_left[0] = 90;
            end
            for (int c = 0; c < CH; c++) begin
                if (seg_left[c] == 0) begin
                    lvl[c] = !lvl[c];
                    seg_left[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 9))
                                                              : int'($urandom_range(10, 90));
                end
                button_in[c] = lvl[c];
                seg_left[c]--;
                dir_up[c] = 1'($urandom_range(0, 1));
                clear[c]  = ($urandom_range(0, 59) == 0);
                if (db_now[c] != db_prev[c] && $urandom_range(0, 3) == 0) clear[c] = 1'b1;
            end
        end
        @(negedge clk);
        done = 1'b1;
        for (int id = 0; id < NI*CH; id++) chk("sb_drained", id / CH, id % CH, sb[id].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
